// File: rtl/leading_one_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined leading-one detector.
package leading_one_pkg;

    localparam logic MODE_LEAD  = 1'b0;
    localparam logic MODE_TRAIL = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int idx_w(input int width);
        return clog2(width) + 1;
    endfunction

    function automatic int num_groups(input int width, input int group);
        return (width + group - 1) / group;
    endfunction

endpackage

// File: rtl/leading_one_pipe_lod_group.sv
// Combinational GROUP-bit priority encoder; mode picks MSB-first or LSB-first.
module lod_group
    import leading_one_pkg::*;
#(
    parameter int GROUP = 8,
    parameter int LIW   = clog2(GROUP)
) (
    input  logic [GROUP-1:0] data,
    input  logic             mode,
    output logic             hit,
    output logic [LIW-1:0]   idx
);

    always_comb begin
        hit = |data;
        idx = '0;
        // Last match in scan order wins, so scan away from the wanted end.
        if (mode == MODE_LEAD) begin
            for (int i = 0; i < GROUP; i++) begin
                if (data[i]) idx = LIW'(i);
            end
        end else begin
            for (int i = GROUP - 1; i >= 0; i--) begin
                if (data[i]) idx = LIW'(i);
            end
        end
    end

endmodule

// File: rtl/leading_one_pipe.sv
// Two-stage pipelined leading/trailing-one detector with valid/ready on both sides.
module leading_one_pipe
    import leading_one_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 8,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_zero,
    output logic             out_mode
);

    localparam int NG  = num_groups(WIDTH, GROUP);
    localparam int LIW = clog2(GROUP);
    localparam int UW  = IDX_W - 1;
    localparam int PW  = NG * GROUP;

    logic [PW-1:0]           pad;
    logic [NG-1:0]           grp_hit;
    logic [NG-1:0][LIW-1:0]  grp_idx;

    logic                    s1_valid_q, s1_valid_d;
    logic [NG-1:0]           s1_hit_q, s1_hit_d;
    logic [NG-1:0][LIW-1:0]  s1_lidx_q, s1_lidx_d;
    logic                    s1_mode_q, s1_mode_d;

    logic                    out_valid_q, out_valid_d;
    logic [IDX_W-1:0]        out_index_q, out_index_d;
    logic                    out_zero_q, out_zero_d;
    logic                    out_mode_q, out_mode_d;

    logic                    s2_adv, s1_adv, in_fire;
    logic                    found;
    logic [UW-1:0]           base;

    always_comb begin
        pad = '0;
        pad[WIDTH-1:0] = in_data;
    end

    for (genvar g = 0; g < NG; g++) begin : g_grp
        lod_group #(
            .GROUP (GROUP),
            .LIW   (LIW)
        ) u_grp (
            .data  (pad[g*GROUP +: GROUP]),
            .mode  (in_mode),
            .hit   (grp_hit[g]),
            .idx   (grp_idx[g])
        );
    end

    always_comb begin
        s2_adv   = !out_valid_q | out_ready;
        s1_adv   = !s1_valid_q | s2_adv;
        in_ready = s1_adv;
        in_fire  = in_valid & s1_adv;
    end

    // Group selector: last hit in scan order wins, as in lod_group.
    always_comb begin
        found = 1'b0;
        base  = '0;
        if (s1_mode_q == MODE_LEAD) begin
            for (int g = 0; g < NG; g++) begin
                if (s1_hit_q[g]) begin
                    found = 1'b1;
                    base  = UW'(g * GROUP) + UW'(s1_lidx_q[g]);
                end
            end
        end else begin
            for (int g = NG - 1; g >= 0; g--) begin
                if (s1_hit_q[g]) begin
                    found = 1'b1;
                    base  = UW'(g * GROUP) + UW'(s1_lidx_q[g]);
                end
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_hit_d    = s1_hit_q;
        s1_lidx_d   = s1_lidx_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_zero_d  = out_zero_q;
        out_mode_d  = out_mode_q;
        if (s1_adv) s1_valid_d = in_valid;
        if (in_fire) begin
            s1_hit_d  = grp_hit;
            s1_lidx_d = grp_idx;
            s1_mode_d = in_mode;
        end
        if (s2_adv) out_valid_d = s1_valid_q;
        if (s2_adv && s1_valid_q) begin
            out_index_d = found ? {1'b0, base} : '1;
            out_zero_d  = !found;
            out_mode_d  = s1_mode_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= '0;
            s1_lidx_q   <= '0;
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_zero_q  <= 1'b0;
            out_mode_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            s1_lidx_q   <= s1_lidx_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_zero_q  <= out_zero_d;
            out_mode_q  <= out_mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_zero  = out_zero_q;
    assign out_mode  = out_mode_q;

endmodule

// File: doc/leading_one_pipe.md
Name: leading_one_pipe

Overview:
- Parametrised, pipelined successor to the combinational leading-one detector.
- Finds the index of the most-significant set bit (mode 0) or the least-significant set bit (mode 1) of a WIDTH-bit word.
- Returns -1 for an all-zero word.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between normalisation/arithmetic datapaths that need a registered priority index at high clock rates.

Parameters:
- WIDTH, 32: input word width; any value >= 2.
- GROUP, 8: bits per first-stage group; 2 <= GROUP <= WIDTH. WIDTH need not be a multiple of GROUP: the top group is zero-padded above bit WIDTH-1.
- IDX_W, $clog2(WIDTH)+1: signed index width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  WIDTH  word to scan.
- in_mode  in  1  0 = leading one (MSB-first); 1 = trailing one (LSB-first).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_index  out  IDX_W  signed bit index, 0..WIDTH-1, or -1 (all ones) when the word is zero.
- out_zero  out  1  input word was all zero.
- out_mode  out  1  in_mode echoed with the result.

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, out_valid=0, out_index=0, out_zero=0, out_mode=0; all pipeline data registers cleared.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage 1 (registered on input transfer):
  - NG = ceil(WIDTH/GROUP) groups.
  - Per group: hit flag = OR of group bits; local index in 0..GROUP-1, chosen MSB-first or LSB-first per in_mode.
  - Stores hits, local indices and mode.
- Stage 2 (registered into the output regs):
  - Selects the highest-numbered hit group (mode 0) or the lowest-numbered hit group (mode 1).
  - out_index = group_number*GROUP + local_index.
  - No hit: out_index = -1 and out_zero = 1.
- Padding bits above WIDTH-1 are always 0, so they never produce a hit.
- Latency: exactly 2 cycles from input transfer to out_valid with no backpressure. Throughput: 1 word/cycle.
- Stall rules:
  - Stage 2 advances when !out_valid | out_ready.
  - Stage 1 advances when !s1_valid | stage 2 advances.
  - in_ready = !s1_valid | stage 2 advances. This is combinational from out_ready, which is permitted.
  - While stalled, out_index, out_zero and out_mode hold stable; no result is dropped or duplicated.
- Simultaneous events: an input transfer and an output transfer in the same cycle both complete; the pipeline holds 2 entries at most.
- Mode is carried per word; mixed-mode back-to-back words are legal.
- Reset mid-operation: in-flight words are discarded; out_valid falls immediately on rst assertion.
- Arithmetic: indices are computed unsigned at IDX_W-1 bits, then zero-extended; -1 is all ones at IDX_W bits.

Decomposition:
- Package leading_one_pkg holds:
  - constants MODE_LEAD=1'b0 and MODE_TRAIL=1'b1;
  - a clog2 helper;
  - the derivation of IDX_W and NG.
- Sub-module lod_group: combinational GROUP-bit priority encoder with a mode input; outputs hit and local index. Instantiated NG times via generate.
- The top level holds both pipeline stages, the group selector and the handshake logic.

Test Plan:
- Defaults, out_ready=1: in_data=32'h0000_0001 mode0 -> out_index=0 two cycles later; 32'h8000_0000 mode0 -> 31; 32'h0001_0100 mode0 -> 16.
- 32'h0000_0000 in either mode -> out_index=-1 (6'h3F), out_zero=1.
- Mode 1: 32'h0001_0100 -> 8; 32'h8000_0000 -> 31; 32'hFFFF_FFFF -> 0; out_mode=1 each time.
- Backpressure: stream 5 words with out_ready=0 for 4 cycles -> in_ready drops after 2 accepted; outputs hold stable; the 5 results emerge in order once out_ready=1.
- Reset mid-stream: assert rst with 2 words in flight -> out_valid=0 in the same cycle; no stale result appears after release.
- WIDTH=9, GROUP=4: sweep 0..511 in both modes against a golden priority task -> all match; 0 gives -1; 256 gives 8 in mode 0 and 8 in mode 1.
